// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART receiver.
// Revision : 1.0
// ============================================================================
package uart_pkg;

   typedef enum logic [2:0] {
      idle   = 3'd0,
      start  = 3'd1,
      data   = 3'd2,
      parity = 3'd3,
      stop   = 3'd4
   } rx_state_t;

   localparam int   OVERSAMPLE = 16;
   localparam int   MID_TICK   = 7;
   localparam logic PARITY_ODD = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop single-bit synchroniser, resets to 1 (idle line level).
// Revision : 1.0
// ============================================================================
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampled UART receiver; optional even parity when
//            UART_RX_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       s_tick,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       frm_err,
   output logic       par_err,
   output logic       rx_busy
);
   import uart_pkg::*;

   localparam logic [4:0] TK_MID  = 5'(MID_TICK);
   localparam logic [4:0] TK_LAST = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] TK_END  = 5'(SB_TICK - 1);
   localparam logic [2:0] BT_LAST = 3'(DBIT - 1);

   logic rx_s;

   sync_2ff u_sync_rx (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   rx_state_t       state_q, state_d;
   logic [4:0]      tk_q, tk_d;
   logic [2:0]      bt_q, bt_d;
   logic [DBIT-1:0] sh_q, sh_d;
   logic [7:0]      dout_q, dout_d;
   logic            done_q, done_d;
   logic            frm_q, frm_d;
   logic            serr_q, serr_d;
   logic [7:0]      dout_ext;
`ifdef UART_RX_PARITY_EN
   logic            pbit_q, pbit_d;
   logic            par_q, par_d;
`endif

   always_comb begin
      state_d  = state_q;
      tk_d     = tk_q;
      bt_d     = bt_q;
      sh_d     = sh_q;
      dout_d   = dout_q;
      done_d   = 1'b0;
      frm_d    = frm_q;
      serr_d   = serr_q;
      dout_ext = '0;
      dout_ext[DBIT-1:0] = sh_q;
`ifdef UART_RX_PARITY_EN
      pbit_d   = pbit_q;
      par_d    = par_q;
`endif
      case (state_q)
         idle: begin
            if (!rx_s) begin
               state_d = start;
               tk_d    = '0;
            end
         end
         start: begin
            if (s_tick) begin
               if (tk_q == TK_MID) begin
                  if (!rx_s) begin
                     state_d = data;
                     tk_d    = '0;
                     bt_d    = '0;
                  end else begin
                     state_d = idle;
                  end
               end else begin
                  tk_d = tk_q + 5'd1;
               end
            end
         end
         data: begin
            if (s_tick) begin
               if (tk_q == TK_LAST) begin
                  sh_d = {rx_s, sh_q[DBIT-1:1]};
                  tk_d = '0;
                  if (bt_q == BT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = parity;
`else
                     state_d = stop;
`endif
                  end else begin
                     bt_d = bt_q + 3'd1;
                  end
               end else begin
                  tk_d = tk_q + 5'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         parity: begin
            if (s_tick) begin
               if (tk_q == TK_LAST) begin
                  pbit_d  = rx_s;
                  tk_d    = '0;
                  state_d = stop;
               end else begin
                  tk_d = tk_q + 5'd1;
               end
            end
         end
`endif
         stop: begin
            // Stop is entered at the centre of the previous bit, so the
            // stop bit's own centre falls one full bit period later.
            if (s_tick) begin
               if (tk_q == TK_LAST) begin
                  serr_d = ~rx_s;
               end
               if (tk_q == TK_END) begin
                  done_d  = 1'b1;
                  dout_d  = dout_ext;
                  frm_d   = serr_d;
`ifdef UART_RX_PARITY_EN
                  par_d   = ((^sh_q) ^ pbit_q) != PARITY_ODD;
`endif
                  state_d = idle;
               end else begin
                  tk_d = tk_q + 5'd1;
               end
            end
         end
         default: state_d = idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= idle;
         tk_q    <= '0;
         bt_q    <= '0;
         sh_q    <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         frm_q   <= 1'b0;
         serr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pbit_q  <= 1'b0;
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tk_q    <= tk_d;
         bt_q    <= bt_d;
         sh_q    <= sh_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         frm_q   <= frm_d;
         serr_q  <= serr_d;
`ifdef UART_RX_PARITY_EN
         pbit_q  <= pbit_d;
         par_q   <= par_d;
`endif
      end
   end

   assign dout         = dout_q;
   assign rx_done_tick = done_q;
   assign frm_err      = frm_q;
   assign rx_busy      = (state_q != idle);
`ifdef UART_RX_PARITY_EN
   assign par_err      = par_q;
`else
   assign par_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx (honours UART_RX_PARITY_EN).
// Revision : 1.0
// ============================================================================
module tb_uart_rx;
   import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
   localparam int FRAME_DONE = 168;
`else
   localparam int FRAME_DONE = 152;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       s_tick;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frm_err;
   logic       par_err;
   logic       rx_busy;

   typedef struct packed {
      logic [7:0] d;
      logic       f;
      logic       p;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   dones    = 0;
   int   tick_div = 4;
   int   tick_cnt = 0;

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .s_tick       (s_tick),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .frm_err      (frm_err),
      .par_err      (par_err),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   initial begin
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_cnt >= tick_div - 1) begin
            tick_cnt = 0;
            s_tick   = 1'b1;
         end else begin
            tick_cnt++;
            s_tick   = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && rx_done_tick) begin
         exp_t e;
         dones++;
         check("busy_on_done", 32'(rx_busy), 32'd0);
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=dout 0x%0h required=no pulse", dout);
         end else begin
            e = sb_q.pop_front();
            check("dout", 32'(dout), 32'(e.d));
            check("frm_err", 32'(frm_err), 32'(e.f));
            check("par_err", 32'(par_err), 32'(e.p));
         end
      end
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (s_tick !== 1'b1) @(posedge clk);
      end
      #2;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_ticks(16);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_low, input logic pbit);
      exp_t e;
      e.d = b;
      e.f = stop_low;
`ifdef UART_RX_PARITY_EN
      e.p = ((^b) ^ pbit) != PARITY_ODD;
`else
      e.p = 1'b0;
`endif
      sb_q.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(pbit);
`endif
      if (stop_low) begin
         // Release before the re-armed start check so no phantom frame forms.
         rx = 1'b0;
         wait_ticks(12);
         rx = 1'b1;
         wait_ticks(4);
      end else begin
         send_bit(1'b1);
      end
   endtask

   initial begin
      int   d0;
      exp_t e;
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_frm", 32'(frm_err), 32'd0);
      check("rst_par", 32'(par_err), 32'd0);
      check("rst_done", 32'(rx_done_tick), 32'd0);
      check("rst_busy", 32'(rx_busy), 32'd0);
      rst = 1'b0;
      wait_ticks(4);

      send_frame(8'hA5, 1'b0, ^8'hA5);
      wait_ticks(20);

      d0 = dones;
      rx = 1'b0;
      wait_ticks(5);
      rx = 1'b1;
      wait_ticks(30);
      check("glitch_no_done", 32'(dones), 32'(d0));
      check("glitch_dout_hold", 32'(dout), 32'hA5);
      check("glitch_frm_hold", 32'(frm_err), 32'd0);
      check("glitch_idle", 32'(rx_busy), 32'd0);

      send_frame(8'h3C, 1'b1, ^8'h3C);
      send_frame(8'h55, 1'b0, ^8'h55);
      wait_ticks(20);

      send_frame(8'h00, 1'b0, ^8'h00);
      send_frame(8'hFF, 1'b0, ^8'hFF);
      send_frame(8'h81, 1'b0, ^8'h81);
      wait_ticks(20);

      d0 = dones;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'(8'h96 >> i));
      rx = 1'(8'h96 >> 3);
      wait_ticks(8);
      check("busy_mid_data", 32'(rx_busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_dout", 32'(dout), 32'd0);
      check("midrst_frm", 32'(frm_err), 32'd0);
      check("midrst_par", 32'(par_err), 32'd0);
      check("midrst_done", 32'(rx_done_tick), 32'd0);
      check("midrst_busy", 32'(rx_busy), 32'd0);
      rst = 1'b0;
      rx  = 1'b1;
      wait_ticks(40);
      check("midrst_no_done", 32'(dones), 32'(d0));
      send_frame(8'h12, 1'b0, ^8'h12);
      wait_ticks(20);

      tick_div = 1;
      wait_ticks(4);
      send_frame(8'hC3, 1'b0, ^8'hC3);
      wait_ticks(20);
      tick_div = 4;
      wait_ticks(4);

      e.d = 8'h00;
      e.f = 1'b1;
      e.p = 1'b0;
      sb_q.push_back(e);
      sb_q.push_back(e);
      rx = 1'b0;
      wait_ticks(2 * FRAME_DONE + 5);
      rx = 1'b1;
      wait_ticks(40);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b1);
      send_frame(8'h07, 1'b0, 1'b0);
      wait_ticks(20);
`endif

      for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
